// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: two-player 4x4 card-matching turn sequencer (cursor, masks, scores, turn timer)
module memory_game_ctrl #(
  parameter int SHOW_CYCLES = 25_000_000,
  parameter int TURN_CYCLES = 250_000_000
) (
  input  logic        VGA_CLK_IN,
  input  logic        rst,
  input  logic        new_game,
  input  logic        move_next,
  input  logic        select,
  output logic [3:0]  block,
  output logic        player,
  output logic [15:0] revealed,
  output logic [15:0] matched,
  output logic [3:0]  score0,
  output logic [3:0]  score1,
  output logic        game_over,
  output logic [1:0]  winner
);
  localparam int TW = $clog2(TURN_CYCLES) > 28 ? $clog2(TURN_CYCLES) : 28;
  localparam int SW = $clog2(SHOW_CYCLES) > 25 ? $clog2(SHOW_CYCLES) : 25;
  localparam logic [2:0] PAIR [16] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                       3'd5, 3'd1, 3'd6, 3'd3, 3'd7, 3'd0, 3'd4, 3'd2};
  typedef enum logic [2:0] {FIRST, SECOND, COMPARE, SHOW, DONE} state_t;
  state_t        r_state, w_next;
  logic [3:0]    r_block, r_first, r_second, r_score0, r_score1;
  logic          r_player;
  logic [15:0]   r_revealed, r_matched, w_pair;
  logic [TW-1:0] r_turn;
  logic [SW-1:0] r_show;
  logic          w_clr, w_turn, w_pick, w_timeout, w_show_done, w_match, w_hit;
  assign w_clr       = rst | new_game;
  assign w_turn      = r_state == FIRST || r_state == SECOND;
  assign w_pick      = select && w_turn && !r_revealed[r_block] && !r_matched[r_block];
  assign w_timeout   = w_turn && r_turn == TW'(TURN_CYCLES - 1);
  assign w_show_done = r_state == SHOW && r_show == SW'(SHOW_CYCLES - 1);
  assign w_match     = PAIR[r_first] == PAIR[r_second];
  assign w_pair      = (16'd1 << r_first) | (16'd1 << r_second);
  assign w_hit       = r_state == COMPARE && w_match;
  always_ff @(posedge VGA_CLK_IN)
    r_state <= w_clr ? FIRST : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      FIRST:   w_next = w_timeout ? FIRST : w_pick ? SECOND : FIRST;
      SECOND:  w_next = w_timeout ? FIRST : w_pick ? COMPARE : SECOND;
      COMPARE: w_next = !w_match ? SHOW : (r_matched | w_pair) == 16'hFFFF ? DONE : FIRST;
      SHOW:    w_next = w_show_done ? FIRST : SHOW;
      DONE:    w_next = DONE;
      default: w_next = FIRST;
    endcase
  end
  always_ff @(posedge VGA_CLK_IN) begin
    if (w_clr) begin
      r_block    <= '0;
      r_first    <= '0;
      r_second   <= '0;
      r_score0   <= '0;
      r_score1   <= '0;
      r_player   <= 1'b0;
      r_revealed <= '0;
      r_matched  <= '0;
      r_turn     <= '0;
      r_show     <= '0;
    end else begin
      if (move_next && r_state != DONE) r_block <= r_block + 4'd1;
      if (w_pick && r_state == FIRST) r_first <= r_block;
      if (w_pick && r_state == SECOND) r_second <= r_block;
      // a fresh turn starts whenever FIRST is (re)entered from anywhere but itself, or on timeout
      r_turn     <= (w_timeout || (r_state != FIRST && w_next == FIRST)) ? '0 : w_turn ? r_turn + TW'(1) : r_turn;
      r_show     <= r_state == SHOW ? r_show + SW'(1) : '0;
      r_revealed <= (w_timeout || w_show_done) ? '0 : w_pick ? r_revealed | (16'd1 << r_block) :
                    w_hit ? r_revealed & ~w_pair : r_revealed;
      if (w_hit) r_matched <= r_matched | w_pair;
      if (w_hit && !r_player) r_score0 <= r_score0 + 4'd1;
      if (w_hit && r_player) r_score1 <= r_score1 + 4'd1;
      if (w_timeout || w_show_done) r_player <= !r_player;
    end
  end
  always_comb begin
    game_over = r_state == DONE;
    winner    = r_state != DONE ? 2'b00 : r_score0 > r_score1 ? 2'b01 : r_score0 < r_score1 ? 2'b10 : 2'b11;
  end
  assign block    = r_block;
  assign player   = r_player;
  assign revealed = r_revealed;
  assign matched  = r_matched;
  assign score0   = r_score0;
  assign score1   = r_score1;
endmodule
